// File: rtl/mem_pkg.sv
// mem_pkg: shared constants for the mem_lat latency memory and its wait-state generator.
package mem_pkg;

   // Fibonacci taps 16,14,13,11 expressed as a mask over lfsr[15:0]
   localparam logic [15:0] LFSR_POLY = 16'hB400;
   localparam logic [15:0] DEF_SEED  = 16'hACE1;
   localparam int          LAT_MAX   = 8;
   localparam logic [1:0]  STALL_MAX = 2'd3;

endpackage

// File: rtl/mem_lfsr.sv
// mem_lfsr: pseudo-random wait-state generator; ack follows lfsr[0] but is never
// held low for more than STALL_MAX consecutive cycles.
module mem_lfsr
   import mem_pkg::*;
#(
   parameter logic [15:0] SEED = DEF_SEED
) (
   input  logic clk,
   input  logic rst,
   output logic ack
);

   logic [15:0] lfsr_q, lfsr_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        ack_q, ack_d;

   // cnt_q tracks how many consecutive cycles ack_q has been low
   always_comb begin
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_POLY)};
      ack_d  = lfsr_q[0] | (cnt_q == STALL_MAX);
      cnt_d  = ack_d ? 2'd0 : cnt_q + 2'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q <= SEED;
         cnt_q  <= 2'd0;
         ack_q  <= 1'b0;
      end else begin
         lfsr_q <= lfsr_d;
         cnt_q  <= cnt_d;
         ack_q  <= ack_d;
      end
   end

   assign ack = ack_q;

endmodule

// File: rtl/mem_lat.sv
// mem_lat: byte-addressable memory with a fully pipelined LAT-cycle read port.
// Define MEM_STALL_EN to insert LFSR-driven wait states on ack.
module mem_lat
   import mem_pkg::*;
#(
   parameter string       FN   = "",
   parameter int          DW   = 32,
   parameter int          SW   = DW/8,
   parameter int          SZ   = 2**12,
   parameter int          AW   = $clog2(SZ),
   parameter int          LAT  = 1,
   parameter logic [15:0] SEED = DEF_SEED
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req,
   input  logic            wen,
   input  logic [SW-1:0]   sel,
   input  logic [AW-1:0]   adr,
   input  logic [SW*8-1:0] wdt,
   output logic            ack,
   output logic [SW*8-1:0] rdt,
   output logic            rvl
);

   localparam int OW    = $clog2(SW);
   localparam int WORDS = SZ / SW;

   logic [SW*8-1:0]  mem [WORDS];
   logic [AW-OW-1:0] widx;
   logic             xfer, wr_xfer, rd_xfer;
   logic [LAT-1:0]   vld_q, vld_d;
   logic [SW*8-1:0]  dat_q [LAT];
   logic [SW*8-1:0]  dat_d [LAT];
   logic             unused_ok;

   assign widx      = adr[AW-1:OW];
   assign xfer      = req & ack;
   assign wr_xfer   = xfer & wen;
   assign rd_xfer   = xfer & ~wen;
   assign unused_ok = ^{SEED, adr, DW[0]};

`ifdef MEM_STALL_EN
   mem_lfsr #(.SEED(SEED)) u_lfsr (
      .clk (clk),
      .rst (rst),
      .ack (ack)
   );
`else
   logic ack_q, ack_d;

   always_comb begin
      ack_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ack_q <= 1'b0;
      else      ack_q <= ack_d;
   end

   assign ack = ack_q;
`endif

   // Storage is deliberately left out of reset so data survives a reset pulse
   always_ff @(posedge clk) begin
      if (wr_xfer) begin
         for (int i = 0; i < SW; i++) begin
            if (sel[i]) mem[widx][i*8 +: 8] <= wdt[i*8 +: 8];
         end
      end
   end

   // Stage data only moves with its valid bit, so the last stage holds rdt between reads
   always_comb begin
      vld_d[0] = rd_xfer;
      dat_d[0] = rd_xfer ? mem[widx] : dat_q[0];
      for (int i = 1; i < LAT; i++) begin
         vld_d[i] = vld_q[i-1];
         dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q <= '0;
         for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

   assign rvl = vld_q[LAT-1];
   assign rdt = dat_q[LAT-1];

endmodule

// File: tb/tb_mem_lat.sv
// tb_mem_lat: directed checks of two mem_lat instances (LAT=3 and LAT=2) driven by shared stimulus.
module tb_mem_lat;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        wen;
   logic [3:0]  sel;
   logic [11:0] adr;
   logic [31:0] wdt;
   logic        ack3, rvl3, ack2, rvl2;
   logic [31:0] rdt3, rdt2;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   mem_lat #(.LAT(3)) dut3 (
      .clk(clk), .rst(rst), .req(req), .wen(wen), .sel(sel), .adr(adr),
      .wdt(wdt), .ack(ack3), .rdt(rdt3), .rvl(rvl3)
   );

   mem_lat #(.LAT(2)) dut2 (
      .clk(clk), .rst(rst), .req(req), .wen(wen), .sel(sel), .adr(adr),
      .wdt(wdt), .ack(ack2), .rdt(rdt2), .rvl(rvl2)
   );

   // Called #1 after an edge; returns #1 after the transfer edge with req dropped
   task automatic issue(input logic w, input logic [3:0] s, input logic [11:0] a, input logic [31:0] d);
      int waited = 0;
      req = 1'b1; wen = w; sel = s; adr = a; wdt = d;
      while (ack3 !== 1'b1 && waited < 16) begin
         @(posedge clk); #1;
         waited++;
      end
      tests++;
      if (ack3 !== 1'b1) begin
         fails++;
         $display("[TB] FAIL ack_wait adr=%h: ack=%b after %0d cycles, required 1", a, ack3, waited);
      end
      @(posedge clk); #1;
      req = 1'b0;
   endtask

   task automatic read_check(input logic [11:0] a, input logic [31:0] exp, input string name);
      issue(1'b0, 4'hA, a, 32'h0);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         tests++;
         if (rvl2 !== (k == 1)) begin
            fails++;
            $display("[TB] FAIL %s rvl2 k=%0d: got %b, required %b", name, k, rvl2, (k == 1));
         end
         tests++;
         if (rvl3 !== (k == 2)) begin
            fails++;
            $display("[TB] FAIL %s rvl3 k=%0d: got %b, required %b", name, k, rvl3, (k == 2));
         end
         if (k >= 1) begin
            tests++;
            if (rdt2 !== exp) begin
               fails++;
               $display("[TB] FAIL %s rdt2 k=%0d: got %h, required %h", name, k, rdt2, exp);
            end
         end
         if (k >= 2) begin
            tests++;
            if (rdt3 !== exp) begin
               fails++;
               $display("[TB] FAIL %s rdt3 k=%0d: got %h, required %h", name, k, rdt3, exp);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; req = 1'b0; wen = 1'b0; sel = 4'h0; adr = 12'h0; wdt = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({ack3, rvl3, ack2, rvl2} !== 4'b0000) begin
         fails++;
         $display("[TB] FAIL reset_ctrl: got ack3/rvl3/ack2/rvl2=%b, required 0000", {ack3, rvl3, ack2, rvl2});
      end
      tests++;
      if (rdt3 !== 32'h0 || rdt2 !== 32'h0) begin
         fails++;
         $display("[TB] FAIL reset_rdt: got rdt3=%h rdt2=%h, required 0", rdt3, rdt2);
      end
      rst = 1'b1;
      tests++;
      if (ack3 !== 1'b0) begin
         fails++;
         $display("[TB] FAIL ack_pre_edge: got %b, required 0", ack3);
      end
      @(posedge clk); #1;
`ifndef MEM_STALL_EN
      tests++;
      if (ack3 !== 1'b1 || ack2 !== 1'b1) begin
         fails++;
         $display("[TB] FAIL ack_first_edge: got ack3=%b ack2=%b, required 1", ack3, ack2);
      end
`endif
   endtask

   task automatic test_write_read();
      issue(1'b1, 4'hF, 12'h010, 32'hDEADBEEF);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         tests++;
         if ({rvl3, rvl2} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL write_no_rvl k=%0d: got rvl3/rvl2=%b, required 00", k, {rvl3, rvl2});
         end
      end
      read_check(12'h010, 32'hDEADBEEF, "rd_10");
   endtask

   task automatic test_byte_sel();
      issue(1'b1, 4'hF, 12'h020, 32'h11223344);
      issue(1'b1, 4'b0101, 12'h020, 32'hAABBCCDD);
      read_check(12'h020, 32'h11BB33DD, "rd_20_sel");
      read_check(12'h022, 32'h11BB33DD, "rd_22_lowbits");
   endtask

`ifndef MEM_STALL_EN
   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) issue(1'b1, 4'hF, 12'(4 * i), 32'(i + 1));
      req = 1'b1; wen = 1'b0; sel = 4'h0; adr = 12'h000;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (c < 3) adr = 12'(4 * (c + 1));
         else       req = 1'b0;
         tests++;
         if (rvl2 !== (c >= 1 && c <= 4)) begin
            fails++;
            $display("[TB] FAIL b2b_rvl2 c=%0d: got %b, required %b", c, rvl2, (c >= 1 && c <= 4));
         end
         tests++;
         if (rvl3 !== (c >= 2 && c <= 5)) begin
            fails++;
            $display("[TB] FAIL b2b_rvl3 c=%0d: got %b, required %b", c, rvl3, (c >= 2 && c <= 5));
         end
         if (c >= 1) begin
            tests++;
            if (rdt2 !== 32'((c > 4) ? 4 : c)) begin
               fails++;
               $display("[TB] FAIL b2b_rdt2 c=%0d: got %h, required %h", c, rdt2, 32'((c > 4) ? 4 : c));
            end
         end
         if (c >= 2) begin
            tests++;
            if (rdt3 !== 32'((c > 5) ? 4 : c - 1)) begin
               fails++;
               $display("[TB] FAIL b2b_rdt3 c=%0d: got %h, required %h", c, rdt3, 32'((c > 5) ? 4 : c - 1));
            end
         end
      end
   endtask
`endif

   task automatic test_reset_inflight();
      issue(1'b0, 4'h0, 12'h010, 32'h0);
      rst = 1'b0;
      #1;
      tests++;
      if ({ack3, rvl3, rvl2} !== 3'b000 || rdt3 !== 32'h0 || rdt2 !== 32'h0) begin
         fails++;
         $display("[TB] FAIL inflight_reset: got ack3/rvl3/rvl2=%b rdt3=%h rdt2=%h, required 000/0/0",
                  {ack3, rvl3, rvl2}, rdt3, rdt2);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         tests++;
         if ({rvl3, rvl2} !== 2'b00 || rdt3 !== 32'h0) begin
            fails++;
            $display("[TB] FAIL inflight_discard k=%0d: got rvl3/rvl2=%b rdt3=%h, required 00/0", k, {rvl3, rvl2}, rdt3);
         end
      end
      read_check(12'h010, 32'hDEADBEEF, "rd_10_post_reset");
      read_check(12'h020, 32'h11BB33DD, "rd_20_post_reset");
   endtask

`ifdef MEM_STALL_EN
   task automatic test_stall();
      int acks = 0, pulses = 0, run = 0, max_run = 0;
      req = 1'b1; wen = 1'b0; sel = 4'h0; adr = 12'h010;
      for (int c = 0; c < 1000; c++) begin
         if (ack3 === 1'b1) begin
            acks++;
            run = 0;
         end else begin
            run++;
            if (run > max_run) max_run = run;
         end
         @(posedge clk); #1;
         if (rvl3 === 1'b1) pulses++;
      end
      req = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (rvl3 === 1'b1) pulses++;
      end
      tests++;
      if (acks >= 1000) begin
         fails++;
         $display("[TB] FAIL stall_seen: got %0d ack-high cycles of 1000, required fewer", acks);
      end
      tests++;
      if (max_run > 3) begin
         fails++;
         $display("[TB] FAIL stall_max_run: got %0d consecutive ack-low cycles, required at most 3", max_run);
      end
      tests++;
      if (pulses != acks) begin
         fails++;
         $display("[TB] FAIL stall_xfers: got %0d rvl pulses, required %0d", pulses, acks);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_write_read();
      test_byte_sel();
`ifndef MEM_STALL_EN
      test_back_to_back();
`endif
      test_reset_inflight();
`ifdef MEM_STALL_EN
      test_stall();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
